// File: rtl/adc_sector_packer_if.sv
// Signal bundle between adc_sector_packer (master) and its ADC/SD-writer environment (slave).
interface adc_sector_packer_if;
  logic       en;
  logic       adc_clk1;
  logic       adc_clk2;
  logic [7:0] adc_in1;
  logic [7:0] adc_in2;
  logic       sec_rdy;
  logic       sec_ack;
  logic [8:0] sec_rd_addr;
  logic [7:0] sec_rd_data;
  logic       overflow;

  modport master (
    input  en, adc_in1, adc_in2, sec_ack, sec_rd_addr,
    output adc_clk1, adc_clk2, sec_rdy, sec_rd_data, overflow
  );

  modport slave (
    output en, adc_in1, adc_in2, sec_ack, sec_rd_addr,
    input  adc_clk1, adc_clk2, sec_rdy, sec_rd_data, overflow
  );
endinterface

// File: rtl/adc_sector_packer.sv
// Dual 8-bit ADC capture into ping-pong 512-byte sector banks with a ready/ack byte read port.
// Define ADC_PACKER_HEADER_EN to prefix each sector with a 4-byte big-endian sequence number.
module adc_sector_packer #(
  parameter int CLK_DIV = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  adc_sector_packer_if.master        bus
);

`ifdef ADC_PACKER_HEADER_EN
  localparam logic [7:0] PTR_START = 8'd2;
`else
  localparam logic [7:0] PTR_START = 8'd0;
`endif
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  // S_IDLE | en low: ADC clocks parked, partial sector discarded
  // S_FILL | en high: one pair written per ADC clock rising edge
  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        adc_clk_q, adc_clk_d;
  logic        wb_q, wb_d;
  logic        rb_q, rb_d;
  logic [7:0]  wptr_q, wptr_d;
  logic [1:0]  full_q, full_d;
  logic [31:0] seq_q, seq_d;
  logic        overflow_q, overflow_d;
  logic [7:0]  rd_data_q, rd_data_d;
`ifdef ADC_PACKER_HEADER_EN
  logic [31:0] hdr0_q, hdr0_d;
  logic [31:0] hdr1_q, hdr1_d;
  logic [31:0] hdr_sel;
`endif

  logic [15:0] mem [0:511];
  logic        mem_we;
  logic [8:0]  mem_waddr;
  logic [15:0] mem_wdata;
  logic [15:0] rd_word;

  logic div_tc;
  logic sample;
  logic ack_ok;

  // ADC clock divider
  always_comb begin
    div_tc    = (div_q == DIV_LAST);
    div_d     = 8'd0;
    adc_clk_d = 1'b0;
    if (bus.en) begin
      div_d     = div_tc ? 8'd0 : div_q + 8'd1;
      adc_clk_d = div_tc ? ~adc_clk_q : adc_clk_q;
    end
    sample = bus.en && div_tc && !adc_clk_q;
  end

  // write-side FSM, bank bookkeeping and read-side release
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    wb_d       = wb_q;
    rb_d       = rb_q;
    full_d     = full_q;
    seq_d      = seq_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;
    mem_waddr  = {wb_q, wptr_q};
    mem_wdata  = {bus.adc_in1, bus.adc_in2};
    ack_ok     = bus.sec_ack && full_q[rb_q];
`ifdef ADC_PACKER_HEADER_EN
    hdr0_d     = hdr0_q;
    hdr1_d     = hdr1_q;
`endif
    case (state_q)
      S_IDLE: begin
        wptr_d = PTR_START;
        if (bus.en) begin
          state_d    = S_FILL;
          overflow_d = 1'b0;
        end
      end
      S_FILL: begin
        if (!bus.en) begin
          state_d = S_IDLE;
          wptr_d  = PTR_START;
        end else if (sample) begin
          if (full_q[wb_q]) begin
            overflow_d = 1'b1;
          end else begin
            mem_we = 1'b1;
            wptr_d = wptr_q + 8'd1;
            if (wptr_q == 8'hFF) begin
              full_d[wb_q] = 1'b1;
              wb_d         = ~wb_q;
              wptr_d       = PTR_START;
              seq_d        = seq_q + 32'd1;
`ifdef ADC_PACKER_HEADER_EN
              // seq only moves at completions, so latching it here equals its value at bank open
              if (wb_q) hdr1_d = seq_q;
              else      hdr0_d = seq_q;
`endif
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (ack_ok) begin
      full_d[rb_q] = 1'b0;
      rb_d         = ~rb_q;
    end
  end

  // registered byte read from the read bank
  always_comb begin
    rd_word   = mem[{rb_q, bus.sec_rd_addr[8:1]}];
    rd_data_d = bus.sec_rd_addr[0] ? rd_word[7:0] : rd_word[15:8];
`ifdef ADC_PACKER_HEADER_EN
    hdr_sel = rb_q ? hdr1_q : hdr0_q;
    if (bus.sec_rd_addr[8:2] == 7'd0) begin
      case (bus.sec_rd_addr[1:0])
        2'd0:    rd_data_d = hdr_sel[31:24];
        2'd1:    rd_data_d = hdr_sel[23:16];
        2'd2:    rd_data_d = hdr_sel[15:8];
        default: rd_data_d = hdr_sel[7:0];
      endcase
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= 8'd0;
      adc_clk_q  <= 1'b0;
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      wptr_q     <= PTR_START;
      full_q     <= 2'b00;
      seq_q      <= 32'd0;
      overflow_q <= 1'b0;
      rd_data_q  <= 8'd0;
`ifdef ADC_PACKER_HEADER_EN
      hdr0_q     <= 32'd0;
      hdr1_q     <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      adc_clk_q  <= adc_clk_d;
      wb_q       <= wb_d;
      rb_q       <= rb_d;
      wptr_q     <= wptr_d;
      full_q     <= full_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      rd_data_q  <= rd_data_d;
`ifdef ADC_PACKER_HEADER_EN
      hdr0_q     <= hdr0_d;
      hdr1_q     <= hdr1_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.adc_clk1    = adc_clk_q;
  assign bus.adc_clk2    = adc_clk_q;
  assign bus.sec_rdy     = full_q[rb_q];
  assign bus.sec_rd_data = rd_data_q;
  assign bus.overflow    = overflow_q;

endmodule
